// File: rtl/axis_update_scheduler.sv
// Serves the X, Y and Z position registers through one shared external 4-bit
// adder-subtractor: each tick snapshots the commands, then runs one ALU pass per axis.
module axis_update_scheduler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [1:0]   mode_x,
  input  logic [1:0]   mode_y,
  input  logic [1:0]   mode_z,
  input  logic [W-1:0] delta_x,
  input  logic [W-1:0] delta_y,
  input  logic [W-1:0] delta_z,
  output logic         alu_mode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_cin,
  input  logic [W-1:0] alu_sum,
  input  logic         alu_cout,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [W-1:0] pos_z,
  output logic [2:0]   wrap,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  typedef enum logic [2:0] {IDLE, SX, SY, SZ, DONE} state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_t       state;
  logic [1:0]   snap_mode_x, snap_mode_y, snap_mode_z;
  logic [W-1:0] snap_delta_x, snap_delta_y, snap_delta_z;

  logic         serving;
  logic [1:0]   cur_mode;
  logic [W-1:0] cur_delta;
  logic [W-1:0] cur_pos;
  logic [W-1:0] next_pos;
  logic         next_wrap;

  // Select the axis being served this cycle; nothing is selected in IDLE/DONE.
  always_comb begin
    serving   = 1'b0;
    cur_mode  = MODE_HOLD;
    cur_delta = '0;
    cur_pos   = '0;
    case (state)
      SX: begin
        serving   = 1'b1;
        cur_mode  = snap_mode_x;
        cur_delta = snap_delta_x;
        cur_pos   = pos_x;
      end
      SY: begin
        serving   = 1'b1;
        cur_mode  = snap_mode_y;
        cur_delta = snap_delta_y;
        cur_pos   = pos_y;
      end
      SZ: begin
        serving   = 1'b1;
        cur_mode  = snap_mode_z;
        cur_delta = snap_delta_z;
        cur_pos   = pos_z;
      end
      default: begin
        serving = 1'b0;
      end
    endcase
  end

  assign alu_mode = serving && (cur_mode == MODE_SUB);
  assign alu_cin  = alu_mode;
  assign alu_a    = cur_pos;
  assign alu_b    = cur_delta;
  assign busy     = (state != IDLE);

  // A subtract reports borrow, which is the inverse of the ALU carry out.
  always_comb begin
    next_pos  = cur_pos;
    next_wrap = 1'b0;
    case (cur_mode)
      MODE_ADD: begin
        next_pos  = alu_sum;
        next_wrap = alu_cout;
      end
      MODE_SUB: begin
        next_pos  = alu_sum;
        next_wrap = ~alu_cout;
      end
      MODE_LOAD: begin
        next_pos  = cur_delta;
        next_wrap = 1'b0;
      end
      default: begin
        next_pos  = cur_pos;
        next_wrap = 1'b0;
      end
    endcase
  end

  // Sequencer: a tick is accepted only in IDLE; any tick while busy is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pos_x        <= '0;
      pos_y        <= '0;
      pos_z        <= '0;
      wrap         <= '0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      snap_mode_x  <= MODE_HOLD;
      snap_mode_y  <= MODE_HOLD;
      snap_mode_z  <= MODE_HOLD;
      snap_delta_x <= '0;
      snap_delta_y <= '0;
      snap_delta_z <= '0;
    end else begin
      overrun <= tick && (state != IDLE);
      done    <= (state == SZ);
      case (state)
        IDLE: begin
          if (tick) begin
            snap_mode_x  <= mode_x;
            snap_mode_y  <= mode_y;
            snap_mode_z  <= mode_z;
            snap_delta_x <= delta_x;
            snap_delta_y <= delta_y;
            snap_delta_z <= delta_z;
            state        <= SX;
          end
        end
        SX: begin
          pos_x   <= next_pos;
          wrap[0] <= next_wrap;
          state   <= SY;
        end
        SY: begin
          pos_y   <= next_pos;
          wrap[1] <= next_wrap;
          state   <= SZ;
        end
        SZ: begin
          pos_z   <= next_pos;
          wrap[2] <= next_wrap;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_update_scheduler.sv
// Bench for axis_update_scheduler: models the external 4-bit adder-subtractor and
// scoreboards each completed pass against an independent position model.
module tb_axis_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] mode_x, mode_y, mode_z;
  logic [3:0] delta_x, delta_y, delta_z;
  logic       alu_mode, alu_cin, alu_cout;
  logic [3:0] alu_a, alu_b, alu_sum;
  logic [3:0] pos_x, pos_y, pos_z;
  logic [2:0] wrap;
  logic       busy, done, overrun;

  logic [4:0] alu_full;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic [2:0] w;
  } expect_t;

  expect_t    sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] mpx, mpy, mpz;
  logic [2:0] mwrap;

  always #5 clk = ~clk;

  // Ripple-carry adder-subtractor: b is inverted when Mode=1, c_in completes two's complement.
  assign alu_full = {1'b0, alu_a} + {1'b0, alu_b ^ {4{alu_mode}}} + {4'b0, alu_cin};
  assign alu_sum  = alu_full[3:0];
  assign alu_cout = alu_full[4];

  axis_update_scheduler #(.W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .mode_x(mode_x), .mode_y(mode_y), .mode_z(mode_z),
    .delta_x(delta_x), .delta_y(delta_y), .delta_z(delta_z),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .wrap(wrap), .busy(busy), .done(done), .overrun(overrun)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelAxis(input logic [1:0] m, input logic [3:0] d, input logic [3:0] p,
                           output logic [3:0] np, output logic nw);
    int s;
    case (m)
      2'b01: begin s = int'(p) + int'(d); np = 4'(s & 15); nw = (s > 15); end
      2'b10: begin s = int'(p) - int'(d); np = 4'(s & 15); nw = (d > p); end
      2'b11: begin np = d; nw = 1'b0; end
      default: begin np = p; nw = 1'b0; end
    endcase
  endtask

  // Drives a tick at a negedge; returns at the negedge inside SX.
  task automatic applyStimulus(input logic [1:0] mx, input logic [3:0] dx,
                               input logic [1:0] my, input logic [3:0] dy,
                               input logic [1:0] mz, input logic [3:0] dz,
                               input bit push);
    expect_t e;
    logic    nw;
    mode_x = mx; delta_x = dx;
    mode_y = my; delta_y = dy;
    mode_z = mz; delta_z = dz;
    tick = 1'b1;
    modelAxis(mx, dx, mpx, mpx, nw); mwrap[0] = nw;
    modelAxis(my, dy, mpy, mpy, nw); mwrap[1] = nw;
    modelAxis(mz, dz, mpz, mpz, nw); mwrap[2] = nw;
    if (push) begin
      e.x = mpx; e.y = mpy; e.z = mpz; e.w = mwrap;
      sb.push_back(e);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic waitIdle();
    repeat (4) @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_pos_x"}, {4'b0, pos_x}, 8'h00);
    checkOutput({tag, "_pos_y"}, {4'b0, pos_y}, 8'h00);
    checkOutput({tag, "_pos_z"}, {4'b0, pos_z}, 8'h00);
    checkOutput({tag, "_wrap"}, {5'b0, wrap}, 8'h00);
    checkOutput({tag, "_busy_done_ovr"}, {5'b0, busy, done, overrun}, 8'h00);
    checkOutput({tag, "_alu"}, {alu_mode, alu_cin, 6'b0}, 8'h00);
    checkOutput({tag, "_alu_ab"}, {alu_a, alu_b}, 8'h00);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0;
    mode_x = 2'b00; mode_y = 2'b00; mode_z = 2'b00;
    delta_x = 4'd0; delta_y = 4'd0; delta_z = 4'd0;
    mpx = 4'd0; mpy = 4'd0; mpz = 4'd0; mwrap = 3'b000;

    // Scoreboard monitor: every done pulse must match the oldest expected pass result.
    fork
      forever begin
        @(negedge clk);
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("sb_unexpected_done", 8'h01, 8'h00);
          end else begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("sb_pos_x", {4'b0, pos_x}, {4'b0, e.x});
            checkOutput("sb_pos_y", {4'b0, pos_y}, {4'b0, e.y});
            checkOutput("sb_pos_z", {4'b0, pos_z}, {4'b0, e.z});
            checkOutput("sb_wrap", {5'b0, wrap}, {5'b0, e.w});
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    checkQuiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Test 1: reset in the middle of a pass discards it.
    $display("[TB] test 1: reset mid-pass");
    applyStimulus(2'b11, 4'd5, 2'b00, 4'd0, 2'b00, 4'd0, 1'b1);
    waitIdle();
    applyStimulus(2'b01, 4'd1, 2'b01, 4'd3, 2'b01, 4'd2, 1'b0);
    @(negedge clk);
    checkOutput("abort_pos_x_before_rst", {4'b0, pos_x}, 8'h06);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkQuiet("midpass_reset");
    rst = 1'b0;
    mpx = 4'd0; mpy = 4'd0; mpz = 4'd0; mwrap = 3'b000;
    repeat (6) @(negedge clk);
    checkOutput("after_reset_busy", {7'b0, busy}, 8'h00);

    // Test 2: add on X, observed one cycle after acceptance.
    $display("[TB] test 2: add x");
    applyStimulus(2'b01, 4'd3, 2'b00, 4'd0, 2'b00, 4'd0, 1'b1);
    checkOutput("t2_busy_sx", {7'b0, busy}, 8'h01);
    checkOutput("t2_alu_a_b_sx", {alu_a, alu_b}, 8'h03);
    @(negedge clk);
    checkOutput("t2_pos_x_e1", {4'b0, pos_x}, 8'h03);
    checkOutput("t2_done_sy", {7'b0, done}, 8'h00);
    repeat (3) @(negedge clk);

    // Test 3: subtract on Y borrows; subtract controls only in SY.
    $display("[TB] test 3: sub y");
    applyStimulus(2'b00, 4'd0, 2'b10, 4'd2, 2'b00, 4'd0, 1'b1);
    checkOutput("t3_alu_ctl_sx", {6'b0, alu_mode, alu_cin}, 8'h00);
    @(negedge clk);
    checkOutput("t3_alu_ctl_sy", {6'b0, alu_mode, alu_cin}, 8'h03);
    checkOutput("t3_alu_ab_sy", {alu_a, alu_b}, 8'h02);
    @(negedge clk);
    checkOutput("t3_alu_ctl_sz", {6'b0, alu_mode, alu_cin}, 8'h00);
    checkOutput("t3_pos_y", {4'b0, pos_y}, 8'h0e);
    @(negedge clk);
    checkOutput("t3_done", {7'b0, done}, 8'h01);
    checkOutput("t3_alu_ctl_done", {6'b0, alu_mode, alu_cin}, 8'h00);
    @(negedge clk);
    checkOutput("t3_idle_done", {6'b0, done, busy}, 8'h00);

    // Test 4: X wraps 15+1, then a hold pass clears its wrap bit.
    $display("[TB] test 4: wrap on x");
    applyStimulus(2'b11, 4'd15, 2'b00, 4'd0, 2'b00, 4'd0, 1'b1);
    waitIdle();
    applyStimulus(2'b01, 4'd1, 2'b00, 4'd0, 2'b01, 4'd7, 1'b1);
    waitIdle();
    checkOutput("t4_wrap_set", {5'b0, wrap}, 8'h01);
    applyStimulus(2'b00, 4'd9, 2'b10, 4'd15, 2'b00, 4'd0, 1'b1);
    waitIdle();
    applyStimulus(2'b10, 4'd3, 2'b00, 4'd0, 2'b01, 4'd12, 1'b1);
    waitIdle();

    // Test 5: load Z uses the snapshot even though the inputs change mid-pass.
    $display("[TB] test 5: load z snapshot");
    applyStimulus(2'b00, 4'd0, 2'b00, 4'd0, 2'b11, 4'd9, 1'b1);
    delta_z = 4'd4; mode_z = 2'b01; delta_x = 4'd8; mode_x = 2'b01;
    waitIdle();
    checkOutput("t5_pos_z", {4'b0, pos_z}, 8'h09);

    // Test 6: ticks during SY and DONE are dropped with an overrun pulse.
    $display("[TB] test 6: overrun");
    mode_z = 2'b00; delta_z = 4'd0;
    applyStimulus(2'b01, 4'd2, 2'b01, 4'd1, 2'b10, 4'd1, 1'b1);
    @(negedge clk);
    tick = 1'b1; mode_x = 2'b11; delta_x = 4'd7; mode_z = 2'b11; delta_z = 4'd6;
    @(negedge clk);
    tick = 1'b0;
    checkOutput("t6_overrun_pulse", {7'b0, overrun}, 8'h01);
    @(negedge clk);
    checkOutput("t6_overrun_clear", {7'b0, overrun}, 8'h00);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checkOutput("t6_done_tick_dropped", {6'b0, overrun, busy}, 8'h02);
    @(negedge clk);
    checkOutput("t6_no_second_pass", {6'b0, overrun, busy}, 8'h00);
    repeat (4) @(negedge clk);
    checkOutput("t6_pos_x_kept", {4'b0, pos_x}, {4'b0, mpx});

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
